// File: rtl/lfsr_trit_stream.sv
// Pseudo-random trit word generator: XNOR Fibonacci LFSR, warm-up discard, valid/ready stream.
// Optional macro LFSR_TRIT_STREAM_LOCKUP_FIX_EN replaces an all-ones reseed with INIT_SEED.
module lfsr_trit_stream #(
    parameter int unsigned           TRITS         = 27,
    parameter logic [2*TRITS-1:0]    TAPS          = 54'h30_0000_0003_0000,
    parameter logic [2*TRITS-1:0]    INIT_SEED     = 54'h1,
    parameter int unsigned           WARMUP_CYCLES = 0
) (
    input  logic                 i_clk,
    input  logic                 i_srst,
    input  logic                 i_seed_load,
    input  logic [2*TRITS-1:0]   i_seed,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*TRITS-1:0]   o_trits,
    output logic [31:0]          o_word_cnt,
    output logic                 o_lockup
);

    localparam int unsigned W        = 2 * TRITS;
    localparam logic [15:0] WarmLast = 16'(WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {StWarm, StLoad, StRun} state_e;

    // With no warm-up the first word is produced on the very next cycle.
    localparam state_e StartState = (WARMUP_CYCLES == 0) ? StLoad : StWarm;

    state_e         state_q, state_d;
    logic [W-1:0]   lfsr_q, lfsr_d;
    logic [W-1:0]   trits_q, trits_d;
    logic [15:0]    wcnt_q, wcnt_d;
    logic           valid_q, valid_d;
    logic [31:0]    cnt_q, cnt_d;
    logic           lockup_q, lockup_d;

    logic [W-1:0]   lfsr_step;
    logic [W-1:0]   trits_map;
    logic [W-1:0]   seed_eff;
    logic           accept;

    assign lfsr_step = {lfsr_q[W-2:0], ~^(lfsr_q & TAPS)};
    assign accept    = valid_q & i_ready;

    // {r1&r0, r0} folds the illegal pair 2'b10 onto 2'b00.
    always_comb begin
        trits_map = '0;
        for (int unsigned k = 0; k < TRITS; k++) begin
            trits_map[2*k +: 2] = {lfsr_q[2*k+1] & lfsr_q[2*k], lfsr_q[2*k]};
        end
    end

`ifdef LFSR_TRIT_STREAM_LOCKUP_FIX_EN
    assign seed_eff = (&i_seed) ? INIT_SEED : i_seed;
    assign lockup_d = i_seed_load & (&i_seed);
`else
    assign seed_eff = i_seed;
    assign lockup_d = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        trits_d = trits_q;
        wcnt_d  = wcnt_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        // A word accepted in the reseed cycle is still counted before being dropped.
        if (accept) begin
            cnt_d = cnt_q + 32'd1;
        end

        if (i_seed_load) begin
            lfsr_d  = seed_eff;
            wcnt_d  = '0;
            valid_d = 1'b0;
            state_d = StartState;
        end else begin
            unique case (state_q)
                StWarm: begin
                    lfsr_d = lfsr_step;
                    wcnt_d = wcnt_q + 16'd1;
                    if (wcnt_q == WarmLast) begin
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    trits_d = trits_map;
                    valid_d = 1'b1;
                    lfsr_d  = lfsr_step;
                    state_d = StRun;
                end
                StRun: begin
                    if (accept) begin
                        trits_d = trits_map;
                        lfsr_d  = lfsr_step;
                    end
                end
                default: begin
                    state_d = StartState;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q  <= StartState;
            lfsr_q   <= INIT_SEED;
            trits_q  <= '0;
            wcnt_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            trits_q  <= trits_d;
            wcnt_q   <= wcnt_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            lockup_q <= lockup_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_trits    = trits_q;
    assign o_word_cnt = cnt_q;
    assign o_lockup   = lockup_q;

    // Stream contract: a stalled word stays put and stays valid.
    assert property (@(posedge i_clk) disable iff (i_srst)
        (valid_q && !i_ready && !i_seed_load) |=> (valid_q && $stable(trits_q)));

    for (genvar g = 0; g < TRITS; g++) begin : g_no_illegal
        assert property (@(posedge i_clk) trits_q[2*g+1:2*g] != 2'b10);
    end

endmodule

// File: tb/tb_lfsr_trit_stream.sv
// Randomised bench for lfsr_trit_stream: two instances (no warm-up, 3-step warm-up) against a
// transaction-level model, plus directed reset, stall, reseed and all-ones-seed cases.
module tb_lfsr_trit_stream;

    localparam int unsigned TRITS = 27;
    localparam int unsigned W     = 2 * TRITS;
    localparam logic [W-1:0] TAPS = 54'h30_0000_0003_0000;
    localparam logic [W-1:0] INIT = 54'h1;
    localparam logic [W-1:0] ONES = {W{1'b1}};

`ifdef LFSR_TRIT_STREAM_LOCKUP_FIX_EN
    localparam bit FixEn = 1'b1;
`else
    localparam bit FixEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           srst = 1'b1;
    logic           seed_load = 1'b0;
    logic           ready = 1'b0;
    logic [W-1:0]   seed = '0;

    logic           v   [2];
    logic [W-1:0]   tr  [2];
    logic [31:0]    wc  [2];
    logic           lk  [2];

    int n_vec = 0;
    int n_err = 0;

    // Model state per instance: pending LFSR value, warm-up steps left, outputs.
    int             warm_n [2] = '{0, 3};
    logic [W-1:0]   m_lf   [2];
    logic [W-1:0]   m_tr   [2];
    int             m_cd   [2];
    bit             m_val  [2];
    logic [31:0]    m_cnt  [2];
    bit             m_lock [2];

    lfsr_trit_stream #(
        .TRITS(TRITS), .TAPS(TAPS), .INIT_SEED(INIT), .WARMUP_CYCLES(0)
    ) u_dut0 (
        .i_clk(clk), .i_srst(srst), .i_seed_load(seed_load), .i_seed(seed),
        .o_valid(v[0]), .i_ready(ready), .o_trits(tr[0]), .o_word_cnt(wc[0]), .o_lockup(lk[0])
    );

    lfsr_trit_stream #(
        .TRITS(TRITS), .TAPS(TAPS), .INIT_SEED(INIT), .WARMUP_CYCLES(3)
    ) u_dut3 (
        .i_clk(clk), .i_srst(srst), .i_seed_load(seed_load), .i_seed(seed),
        .o_valid(v[1]), .i_ready(ready), .o_trits(tr[1]), .o_word_cnt(wc[1]), .o_lockup(lk[1])
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Next register value: shift left, feed back 1 when the tapped bits have even parity.
    function automatic logic [W-1:0] ref_step(input logic [W-1:0] l);
        int ones = $countones(l & TAPS);
        return {l[W-2:0], ((ones % 2) == 0) ? 1'b1 : 1'b0};
    endfunction

    // Each pair is copied, except the illegal value 2 which becomes 0.
    function automatic logic [W-1:0] ref_map(input logic [W-1:0] l);
        logic [W-1:0] r = '0;
        for (int k = 0; k < TRITS; k++) begin
            r[2*k +: 2] = (l[2*k +: 2] == 2'b10) ? 2'b00 : l[2*k +: 2];
        end
        return r;
    endfunction

    function automatic bit has_pair10(input logic [W-1:0] t);
        bit f = 1'b0;
        for (int k = 0; k < TRITS; k++) begin
            if (t[2*k +: 2] == 2'b10) f = 1'b1;
        end
        return f;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (srst) begin
                m_lf[d] = INIT; m_cd[d] = warm_n[d]; m_val[d] = 1'b0;
                m_tr[d] = '0; m_cnt[d] = '0; m_lock[d] = 1'b0;
            end else begin
                bit acc = m_val[d] && ready;
                m_lock[d] = 1'b0;
                if (acc) m_cnt[d] = m_cnt[d] + 32'd1;
                if (seed_load) begin
                    m_lock[d] = FixEn && (seed == ONES);
                    m_lf[d]   = m_lock[d] ? INIT : seed;
                    m_cd[d]   = warm_n[d];
                    m_val[d]  = 1'b0;
                end else if (!m_val[d]) begin
                    if (m_cd[d] == 0) begin
                        m_tr[d]  = ref_map(m_lf[d]);
                        m_val[d] = 1'b1;
                    end else begin
                        m_cd[d]--;
                    end
                    m_lf[d] = ref_step(m_lf[d]);
                end else if (acc) begin
                    m_tr[d] = ref_map(m_lf[d]);
                    m_lf[d] = ref_step(m_lf[d]);
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d_valid", d), 64'(v[d]), 64'(m_val[d]));
            check_eq($sformatf("d%0d_trits", d), 64'(tr[d]), 64'(m_tr[d]));
            check_eq($sformatf("d%0d_cnt", d), 64'(wc[d]), 64'(m_cnt[d]));
            check_eq($sformatf("d%0d_lockup", d), 64'(lk[d]), 64'(m_lock[d]));
            if (v[d]) check_eq($sformatf("d%0d_no_pair10", d), 64'(has_pair10(tr[d])), 64'd0);
        end
    endtask

    task automatic do_reset();
        srst = 1'b1; seed_load = 1'b0;
        cycle(); cycle();
        srst = 1'b0;
    endtask

    logic [W-1:0] s1_words [4] = '{54'h1, 54'h3, 54'h7, 54'hF};

    initial begin
        logic [31:0] cnt_before;
        int n;

        // Reset state and first words, no stall.
        ready = 1'b1;
        do_reset();
        check_eq("rst_valid", 64'(v[0]), 64'd0);
        check_eq("rst_trits", 64'(tr[0]), 64'd0);
        check_eq("rst_cnt", 64'(wc[0]), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("s1_trits", 64'(tr[0]), 64'(s1_words[i]));
            check_eq("s1_cnt", 64'(wc[0]), 64'(i));
            check_eq("s4_valid", 64'(v[1]), (i == 3) ? 64'd1 : 64'd0);
        end
        check_eq("s4_first_word", 64'(tr[1]), 64'hF);
        cycle();
        check_eq("s1_cnt4", 64'(wc[0]), 64'd4);

        // Stall for five cycles on the second word.
        do_reset();
        ready = 1'b1;
        cycle(); cycle();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("s2_hold_trits", 64'(tr[0]), 64'h3);
            check_eq("s2_hold_cnt", 64'(wc[0]), 64'd1);
        end
        ready = 1'b1;
        cycle();
        check_eq("s2_release", 64'(tr[0]), 64'h7);

        // Reseed with a value whose only set pair is the illegal one.
        seed = 54'h2; seed_load = 1'b1;
        cycle();
        seed_load = 1'b0;
        cycle();
        check_eq("s3_valid", 64'(v[0]), 64'd1);
        check_eq("s3_first_word", 64'(tr[0]), 64'h0);

        // Reseed coinciding with an accept, then again mid-warm-up.
        cnt_before = m_cnt[0];
        seed = {$urandom, $urandom}; seed_load = 1'b1;
        cycle();
        seed_load = 1'b0;
        check_eq("s5_cnt_once", 64'(wc[0]), 64'(cnt_before + 32'd1));
        check_eq("s5_valid_drop", 64'(v[0]), 64'd0);
        cycle(); cycle();
        seed = {$urandom, $urandom}; seed_load = 1'b1;
        cycle();
        seed_load = 1'b0;
        n = 0;
        while (!v[1] && n < 20) begin
            cycle();
            n++;
        end
        check_eq("s5_rewarm_latency", 64'(n), 64'd4);

        // All-ones seed.
        seed = ONES; seed_load = 1'b1;
        cycle();
        seed_load = 1'b0;
        check_eq("s6_lockup_pulse", 64'(lk[0]), 64'(FixEn));
        cycle();
        check_eq("s6_lockup_clear", 64'(lk[0]), 64'd0);
        check_eq("s6_word0", 64'(tr[0]), FixEn ? 64'h1 : 64'(ONES));
        cycle(); cycle();
        check_eq("s6_word2", 64'(tr[0]), FixEn ? 64'h7 : 64'(ONES));

        // Randomised traffic with occasional reseeds and resets.
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            ready     = ($urandom_range(0, 9) < 7);
            seed_load = ($urandom_range(0, 499) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? ONES : {$urandom, $urandom};
            srst      = ($urandom_range(0, 2999) == 0);
            cycle();
        end
        srst = 1'b0; seed_load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
